// File: rtl/tdsp_sample_dma.sv
// rtl/tdsp_sample_dma.sv - sample-capture DMA into ping-pong sample RAM (option: TDSP_SAMPLE_DMA_HALF_IRQ_EN adds half_done)
module tdsp_sample_dma #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_BITS   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dma_enable,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_ready,
  output logic                  bus_request,
  input  logic                  bus_grant,
  output logic                  dma_write,
  output logic [IDX_BITS:0]     dma_address,
  output logic [DATA_WIDTH-1:0] dma_data,
  output logic                  top_buf_flag,
  output logic                  buf_done,
  output logic                  overrun,
  input  logic                  overrun_clr
`ifdef TDSP_SAMPLE_DMA_HALF_IRQ_EN
  ,
  output logic                  half_done
`endif
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [CNT_BITS-1:0]   count;
  logic [CNT_BITS-1:0]   count_after;
  logic                  ready_en;
  logic [IDX_BITS-1:0]   wr_idx;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  last_idx;

  // ready_en holds sample_ready low until the first clock after reset release
  assign full         = (count == CNT_BITS'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign sample_ready = ready_en && !full;
  assign push         = sample_valid && sample_ready;
  assign drop         = sample_valid && ready_en && full;
  assign pop          = (state == XFER);
  assign count_after  = count + CNT_BITS'(push) - CNT_BITS'(pop);
  assign last_idx     = &wr_idx;
  assign dma_address  = {top_buf_flag, wr_idx};
  assign dma_data     = dma_write ? fifo_mem[rd_ptr] : '0;

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sample_data;
  end

  // FIFO pointers, write index, buffer half flag and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wr_idx       <= '0;
      top_buf_flag <= 1'b0;
      buf_done     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      count    <= count_after;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        wr_idx <= wr_idx + 1'b1;
        if (last_idx) top_buf_flag <= ~top_buf_flag;
      end
      buf_done <= pop && last_idx;
      // a drop in the same cycle as a clear wins
      if (drop) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

`ifdef TDSP_SAMPLE_DMA_HALF_IRQ_EN
  // mid-half pulse after the write to the last index of the lower quarter-range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) half_done <= 1'b0;
    else       half_done <= pop && (wr_idx == IDX_BITS'(2 ** (IDX_BITS - 1) - 1));
  end
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next state and bus outputs; an XFER always completes once entered
  always_comb begin
    state_next  = state;
    bus_request = 1'b0;
    dma_write   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && dma_enable) state_next = REQ;
      end
      REQ: begin
        bus_request = 1'b1;
        if (!dma_enable)    state_next = IDLE;
        else if (bus_grant) state_next = XFER;
      end
      XFER: begin
        bus_request = 1'b1;
        dma_write   = 1'b1;
        if ((count_after != '0) && dma_enable) state_next = REQ;
        else                                   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tdsp_sample_dma.sv
// tb/tb_tdsp_sample_dma.sv - directed self-checking bench for tdsp_sample_dma
module tb_tdsp_sample_dma;

  logic       clk;
  logic       reset;
  logic       dma_enable;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       sample_ready;
  logic       bus_request;
  logic       bus_grant;
  logic       dma_write;
  logic [7:0] dma_address;
  logic [7:0] dma_data;
  logic       top_buf_flag;
  logic       buf_done;
  logic       overrun;
  logic       overrun_clr;
`ifdef TDSP_SAMPLE_DMA_HALF_IRQ_EN
  logic       half_done;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int buf_at[$];
  int half_at[$];

  tdsp_sample_dma dut (
    .clk          (clk),
    .reset        (reset),
    .dma_enable   (dma_enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .bus_request  (bus_request),
    .bus_grant    (bus_grant),
    .dma_write    (dma_write),
    .dma_address  (dma_address),
    .dma_data     (dma_data),
    .top_buf_flag (top_buf_flag),
    .buf_done     (buf_done),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
`ifdef TDSP_SAMPLE_DMA_HALF_IRQ_EN
    ,
    .half_done    (half_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write/pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (buf_done) buf_at.push_back(log_addr.size());
`ifdef TDSP_SAMPLE_DMA_HALF_IRQ_EN
    if (half_done) half_at.push_back(log_addr.size());
`endif
    if (dma_write) begin
      log_addr.push_back(int'(dma_address));
      log_data.push_back(int'(dma_data));
      log_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    buf_at.delete();
    half_at.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // offer samples only while sample_ready so nothing is dropped
  task automatic push_stream(input string tag, input int start, input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 5000) begin
      if (sample_ready) begin
        sample_valid = 1'b1;
        sample_data  = 8'(start + i);
        i++;
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    sample_valid = 1'b0;
    check_eq({tag, "_pushed"}, i, n);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus_request) quiet = 0;
      else quiet++;
    end
    check_eq({tag, "_drain"}, int'(quiet >= 2), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    reset        = 1'b1;
    dma_enable   = 1'b1;
    sample_valid = 1'b0;
    sample_data  = 8'h00;
    bus_grant    = 1'b1;
    overrun_clr  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready",   int'(sample_ready), 0);
    check_eq("rst_req",     int'(bus_request),  0);
    check_eq("rst_write",   int'(dma_write),    0);
    check_eq("rst_overrun", int'(overrun),      0);
    check_eq("rst_top",     int'(top_buf_flag), 0);
    check_eq("rst_bufdone", int'(buf_done),     0);
    check_eq("rst_addr",    int'(dma_address),  0);
    check_eq("rst_data",    int'(dma_data),     0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", int'(sample_ready), 1);

    // single sample latency
    sample_valid = 1'b1;
    sample_data  = 8'hA5;
    @(negedge clk);
    sample_valid = 1'b0;
    check_eq("lat_c1_write", int'(dma_write), 0);
    @(negedge clk);
    check_eq("lat_c2_write", int'(dma_write), 0);
    @(negedge clk);
    check_eq("lat_c3_write", int'(dma_write),    1);
    check_eq("lat_addr",     int'(dma_address),  8'h00);
    check_eq("lat_data",     int'(dma_data),     8'hA5);
    check_eq("lat_top",      int'(top_buf_flag), 0);

    // stream across the half boundary
    do_reset();
    clear_logs();
    push_stream("strm", 0, 200);
    wait_idle("strm");
    check_eq("strm_count", log_addr.size(), 200);
    for (int k = 0; k < log_addr.size(); k++)
      check_eq($sformatf("strm_w%0d", k), (log_addr[k] << 8) | log_data[k], (k << 8) | (k & 255));
    check_eq("strm_bufdone_n", buf_at.size(), 1);
    if (buf_at.size() > 0) check_eq("strm_bufdone_at", buf_at[0], 128);
    check_eq("strm_top", int'(top_buf_flag), 1);
`ifdef TDSP_SAMPLE_DMA_HALF_IRQ_EN
    check_eq("half_n", half_at.size(), 2);
    if (half_at.size() > 1) begin
      check_eq("half_at0", half_at[0], 64);
      check_eq("half_at1", half_at[1], 192);
    end
`endif

    // grant withheld, FIFO fills and overruns
    bus_grant = 1'b0;
    do_reset();
    clear_logs();
    for (int k = 0; k < 6; k++) begin
      sample_valid = 1'b1;
      sample_data  = 8'(8'h10 + k);
      @(negedge clk);
      if (k == 3) begin
        check_eq("full_ready", int'(sample_ready), 0);
        check_eq("full_ovr0",  int'(overrun),      0);
      end
      if (k == 4) check_eq("full_ovr1", int'(overrun), 1);
    end
    sample_valid = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("stall_req",    int'(bus_request), 1);
    check_eq("stall_writes", log_addr.size(),   0);
    bus_grant = 1'b1;
    wait_idle("stall");
    check_eq("stall_count", log_addr.size(), 4);
    for (int k = 0; k < log_addr.size(); k++)
      check_eq($sformatf("stall_w%0d", k), (log_addr[k] << 8) | log_data[k], (k << 8) | (8'h10 + k));

    // overrun clear and set-over-clear priority
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check_eq("ovr_clr", int'(overrun), 0);
    bus_grant = 1'b0;
    push_stream("ovrfill", 8'h20, 4);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check_eq("ovr_set", int'(overrun), 1);
    sample_valid = 1'b1;
    overrun_clr  = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    overrun_clr  = 1'b0;
    check_eq("ovr_prio", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check_eq("ovr_clr2", int'(overrun), 0);
    bus_grant = 1'b1;
    wait_idle("ovr");

    // dma_enable gating
    dma_enable = 1'b0;
    do_reset();
    clear_logs();
    push_stream("ena", 8'h31, 3);
    repeat (5) @(negedge clk);
    check_eq("ena_req",    int'(bus_request),  0);
    check_eq("ena_writes", log_addr.size(),    0);
    check_eq("ena_ready",  int'(sample_ready), 1);
    dma_enable = 1'b1;
    wait_idle("ena");
    check_eq("ena_count", log_addr.size(), 3);
    for (int k = 0; k < log_addr.size(); k++)
      check_eq($sformatf("ena_w%0d", k), (log_addr[k] << 8) | log_data[k], (k << 8) | (8'h31 + k));
    if (log_cyc.size() == 3) begin
      check_eq("ena_gap01", log_cyc[1] - log_cyc[0], 2);
      check_eq("ena_gap12", log_cyc[2] - log_cyc[1], 2);
    end

    // reset asserted in the middle of an XFER
    do_reset();
    clear_logs();
    push_stream("pre", 0, 133);
    wait_idle("pre");
    check_eq("pre_count", log_addr.size(), 133);
    sample_valid = 1'b1;
    sample_data  = 8'hEE;
    @(negedge clk);
    sample_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      if (dma_write) found = 1;
      else @(negedge clk);
    end
    check_eq("mid_seen", found, 1);
    check_eq("mid_addr", int'(dma_address), 8'h85);
    check_eq("mid_data", int'(dma_data),    8'hEE);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_write", int'(dma_write),   0);
    check_eq("mid_rst_req",   int'(bus_request), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("after_top",   int'(top_buf_flag), 0);
    check_eq("after_ready", int'(sample_ready), 1);
    clear_logs();
    push_stream("after", 8'h5A, 1);
    wait_idle("after");
    check_eq("after_count", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      check_eq("after_addr", log_addr[0], 8'h00);
      check_eq("after_data", log_data[0], 8'h5A);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
